booth_mac_accumulator: RTL and testbench
========================================

# booth_mac_accumulator

Signed multiply-accumulate back end that sits directly downstream of `modified_booth_multiplier_sync`. It consumes that multiplier's registered 16-bit two's-complement products and sums a programmed number of them into a saturating accumulator. The finished sum is presented on a valid/ready output port. Together with the multiplier it forms a dot-product unit for 8-bit signed vectors.

## Interface
Parameters:
- `PROD_W`, 16: product width; matches the multiplier output.
- `ACC_W`, 24: accumulator width, signed; must be ≥ `PROD_W`.
- `MAX_TERMS`, 16: maximum number of products per accumulation.
- `CNT_W`, `$clog2(MAX_TERMS)+1`: width of the term count (derived).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a new accumulation; honoured only in IDLE.
- `num_terms`  in  CNT_W  number of products to sum, 0..`MAX_TERMS`; sampled with `start`.
- `in_valid`  in  1  `product` is valid; aligned by the upstream wrapper to the multiplier's one-cycle latency.
- `in_ready`  out  1  accumulator accepts a product this cycle.
- `product`  in  PROD_W  signed product from the multiplier.
- `out_valid`  out  1  `acc_out` holds a finished sum.
- `out_ready`  in  1  consumer accepts `acc_out`.
- `acc_out`  out  ACC_W  signed accumulated result.
- `sat_flag`  out  1  sticky flag: saturation occurred during this accumulation.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On `start`: latch `num_terms`, clear the accumulator, term counter and `sat_flag`.
  - Go to ACCUM if `num_terms` ≠ 0; otherwise go straight to DONE with a zero sum.
  - `num_terms` > `MAX_TERMS` is clamped to `MAX_TERMS`.
- ACCUM:
  - `in_ready` = 1.
  - On each `in_valid && in_ready`: accumulator ← sat(acc + sign_extend(`product`)) and counter increments.
  - The handshake that brings the counter to `num_terms` moves the FSM to DONE.
  - Cycles with `in_valid` = 0 are stalls; nothing changes.
- DONE:
  - `out_valid` = 1; `acc_out` and `sat_flag` are held stable.
  - `out_valid && out_ready` moves the FSM to IDLE.
  - `acc_out` and `sat_flag` keep their last values in IDLE until the next `start`.
- `start` is ignored in ACCUM and DONE.
- Arithmetic:
  - The sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W−1)−1 it clamps to the maximum; below −2^(ACC_W−1) it clamps to the minimum.
  - Either clamp sets `sat_flag`. Once set, `sat_flag` stays set until the next `start`.
  - Subsequent terms add to the clamped value.

## Timing
- Reset values: state IDLE; `in_ready` 0, `out_valid` 0, `busy` 0, `acc_out` 0, `sat_flag` 0; counter 0.
- An asserted `rst_n` aborts any operation immediately, without waiting for a clock edge.
- `start` at edge t: `in_ready` and `busy` are high from t+1.
- Last product accepted at edge k: `out_valid` is high from k+1, carrying the final sum.
- Minimum loop is N+2 cycles (start, N products, one output cycle) with no stalls.
- `in_ready` is a pure decode of the state; it has no combinational dependency on `in_valid`.
- `out_valid` is registered and does not depend on `out_ready`.
- No products are accepted in DONE, so upstream must hold or stall its data.

## Structure
- Shared package/header `booth_pkg` holds:
  - state encodings `ST_IDLE`, `ST_ACCUM`, `ST_DONE`;
  - default widths `PROD_W`, `ACC_W`, `MAX_TERMS`.
- The multiplier and this block both use `booth_pkg`.
- One sub-module: `sat_adder`, a combinational adder with parameters `ACC_W` and `PROD_W`. Inputs are `acc` and `prod`; outputs are `sum` and `ovf`.
- The FSM, counter and registers live in the top module.

## Test plan
- Basic sum: `num_terms`=5 with products −405, 100, −100, 16384, −1280 → `acc_out`=14699 (0x00396B), `sat_flag`=0, `out_valid` one cycle after the 5th handshake.
- Stalls and backpressure: same vectors with `in_valid` low on alternate cycles, then `out_ready` held low 3 cycles → identical result; `acc_out` stable and `out_valid` high throughout the hold.
- Saturation with `ACC_W`=18:
  - 9 × 16384 → 131071 (0x1FFFF), `sat_flag`=1.
  - 9 × −16256 → −131072 (0x20000), `sat_flag`=1.
- `num_terms`=0 → `out_valid` the cycle after `start`, `acc_out`=0, no `in_ready` pulse.
- Ignored start and reset: `start` pulsed in ACCUM → no effect. Then `rst_n` dropped mid-accumulation → all outputs return to their reset values immediately. A following `start` with 2 × 100 → 200.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier and its MAC accumulator back end.
package booth_pkg;

  // Default datapath widths shared by the multiplier and the accumulator.
  localparam int DEFAULT_PROD_W    = 16;
  localparam int DEFAULT_ACC_W     = 24;
  localparam int DEFAULT_MAX_TERMS = 16;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/booth_mac_accumulator_sat_adder.sv
// Combinational saturating adder: signed accumulator plus sign-extended product.
module sat_adder #(
  parameter int ACC_W  = 24,
  parameter int PROD_W = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  localparam int EXT_W = ACC_W + 1 - PROD_W;

  logic signed [ACC_W:0] wide_sum;

  // Add at ACC_W+1 bits, then clamp to the ACC_W range when the top two bits disagree.
  always_comb begin
    wide_sum = {acc[ACC_W-1], acc} + {{EXT_W{prod[PROD_W-1]}}, prod};
    ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    sum      = wide_sum[ACC_W-1:0];
    if (ovf) begin
      if (wide_sum[ACC_W]) begin
        sum = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Saturating multiply-accumulate back end: sums a programmed number of signed
// products and presents the result on a valid/ready port.
module booth_mac_accumulator #(
  parameter int PROD_W    = booth_pkg::DEFAULT_PROD_W,
  parameter int ACC_W     = booth_pkg::DEFAULT_ACC_W,
  parameter int MAX_TERMS = booth_pkg::DEFAULT_MAX_TERMS,
  parameter int CNT_W     = $clog2(MAX_TERMS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              sat_flag,
  output logic              busy
);

  import booth_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  acc_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        terms_q, terms_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;

  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic [CNT_W-1:0]        terms_clamped;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    accept;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .acc  (acc_q),
    .prod ($signed(product)),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  // Shared decode terms used by both the FSM and the datapath.
  always_comb begin
    terms_clamped = (num_terms > MAX_CNT) ? MAX_CNT : num_terms;
    cnt_inc       = cnt_q + CNT_W'(1);
    accept        = (state_q == ST_ACCUM) && in_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the handshake that reaches the programmed count finishes the sum.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (terms_clamped == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept && (cnt_inc == terms_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of registered state.
  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    acc_out   = acc_q;
    sat_flag  = sat_q;
  end

  // Datapath registers: term count, latched length, running sum and sticky saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      terms_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      terms_q <= terms_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  // Datapath next values: clear on start, accumulate on each accepted product.
  always_comb begin
    cnt_d   = cnt_q;
    terms_d = terms_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    if ((state_q == ST_IDLE) && start) begin
      cnt_d   = '0;
      terms_d = terms_clamped;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_inc;
      acc_d = add_sum;
      sat_d = sat_q | add_ovf;
    end
  end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed bench for booth_mac_accumulator: a default 24-bit instance and an
// 18-bit instance share the same stimulus so saturation can be exercised.
module tb_booth_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  num_terms;
  logic        in_valid;
  logic [15:0] product;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, sat_a, busy_a;
  logic [23:0] acc_a;
  logic        in_ready_b, out_valid_b, sat_b, busy_b;
  logic [17:0] acc_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mac_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .product   (product),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .acc_out   (acc_a),
    .sat_flag  (sat_a),
    .busy      (busy_a)
  );

  booth_mac_accumulator #(.ACC_W(18)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .product   (product),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .acc_out   (acc_b),
    .sat_flag  (sat_b),
    .busy      (busy_b)
  );

  task automatic check_val(input string tag, input logic signed [31:0] got,
                           input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start     = 1'b1;
    num_terms = n[4:0];
    tick();
    start     = 1'b0;
  endtask

  task automatic push(input int p);
    logic [31:0] pv;
    pv       = p;
    in_valid = 1'b1;
    product  = pv[15:0];
    tick();
    in_valid = 1'b0;
  endtask

  int vec[5] = '{-405, 100, -100, 16384, -1280};

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_terms = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_val("rst_in_ready",  in_ready_a, 0);
    check_val("rst_out_valid", out_valid_a, 0);
    check_val("rst_busy",      busy_a, 0);
    check_val("rst_acc",       $signed(acc_a), 0);
    check_val("rst_sat",       sat_a, 0);
    rst_n = 1'b1;
    tick();

    // Basic five-term sum
    do_start(5);
    check_val("t1_in_ready", in_ready_a, 1);
    check_val("t1_busy",     busy_a, 1);
    for (int i = 0; i < 4; i++) push(vec[i]);
    check_val("t1_not_done", out_valid_a, 0);
    push(vec[4]);
    check_val("t1_out_valid", out_valid_a, 1);
    check_val("t1_in_ready_low", in_ready_a, 0);
    check_val("t1_acc",  $signed(acc_a), 14699);
    check_val("t1_sat",  sat_a, 0);
    check_val("t1_acc18", $signed(acc_b), 14699);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t1_idle_valid", out_valid_a, 0);
    check_val("t1_idle_busy",  busy_a, 0);
    check_val("t1_idle_acc",   $signed(acc_a), 14699);

    // Same vectors with stalls, then output backpressure
    do_start(5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t2_stall_nodone", out_valid_a, 0);
      push(vec[i]);
    end
    for (int i = 0; i < 3; i++) begin
      check_val("t2_hold_valid", out_valid_a, 1);
      check_val("t2_hold_acc",   $signed(acc_a), 14699);
      tick();
    end
    check_val("t2_hold_sat", sat_a, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("t2_released", out_valid_a, 0);

    // Positive saturation on the 18-bit instance
    do_start(9);
    for (int i = 0; i < 9; i++) push(16384);
    check_val("t3_pos_valid", out_valid_b, 1);
    check_val("t3_pos_acc18", $signed(acc_b), 131071);
    check_val("t3_pos_sat18", sat_b, 1);
    check_val("t3_pos_acc24", $signed(acc_a), 147456);
    check_val("t3_pos_sat24", sat_a, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Negative saturation on the 18-bit instance
    do_start(9);
    for (int i = 0; i < 9; i++) push(-16256);
    check_val("t3_neg_acc18", $signed(acc_b), -131072);
    check_val("t3_neg_sat18", sat_b, 1);
    check_val("t3_neg_acc24", $signed(acc_a), -146304);
    check_val("t3_neg_sat24", sat_a, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero-length accumulation goes straight to DONE
    do_start(0);
    check_val("t4_valid",    out_valid_a, 1);
    check_val("t4_in_ready", in_ready_a, 0);
    check_val("t4_acc",      $signed(acc_a), 0);
    check_val("t4_sat18",    sat_b, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Start pulsed mid-accumulation is ignored
    do_start(3);
    push(100);
    start     = 1'b1;
    num_terms = 5'd1;
    tick();
    start = 1'b0;
    check_val("t5_busy", busy_a, 1);
    push(100);
    check_val("t5_ignored_valid", out_valid_a, 0);
    check_val("t5_ignored_acc",   $signed(acc_a), 200);

    // Asynchronous reset mid-accumulation
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t5_arst_in_ready", in_ready_a, 0);
    check_val("t5_arst_busy",     busy_a, 0);
    check_val("t5_arst_acc",      $signed(acc_a), 0);
    check_val("t5_arst_valid",    out_valid_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2);
    push(100);
    push(100);
    check_val("t5_after_valid", out_valid_a, 1);
    check_val("t5_after_acc",   $signed(acc_a), 200);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
